q2_sched: RTL
=============

Q2_SCHED -- requirements
Module: q2_sched

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the per-requester grant counters.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  each requester has a command pending.
REQ-005 req0_ready / req1_ready  output  1  the command is accepted this cycle.
REQ-006 req0_d / req1_d  input  16  data operand for the address unit.
REQ-007 req0_c, req0_s / req1_c, req1_s  input  1 each  mode bits for the address unit.
REQ-008 q2_d  output  16;  q2_c, q2_s  output  1 each  drive the shared address unit.
REQ-009 q2_address  input  16  combinational result returned by the address unit.
REQ-010 rsp_valid  output  1;  rsp_id  output  1;  rsp_addr  output  16  response to the granted requester.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 grant_cnt0 / grant_cnt1  output  CNT_W  number of accepted commands per requester.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-014 IDLE transitions:
- If any reqN_valid is high, assert the winner's reqN_ready combinationally.
- Latch the winner's d, c and s into q2_d, q2_c and q2_s.
- Latch the winner's index into rsp_id.
- Go to ISSUE.
REQ-015 In ISSUE, q2_d, q2_c and q2_s SHALL hold for exactly one cycle; q2_address SHALL be registered into rsp_addr at the end of that cycle; the FSM SHALL go to RESP.
REQ-016 RESP SHALL assert rsp_valid with rsp_id and rsp_addr stable until rsp_ready is high; on that handshake the FSM SHALL return to IDLE.
REQ-017 Minimum latency SHALL be: accept at cycle N, rsp_valid at N+2; peak throughput is one command per 3 cycles.
REQ-018 Arbitration SHALL be round-robin:
- A register last_gnt SHALL record the last winner.
- When both requesters are valid, the requester other than last_gnt wins.
- When one requester is valid, it wins.
REQ-019 reqN_ready SHALL be low outside IDLE and low for the losing requester.
REQ-020 Requesters SHALL hold valid and payload stable until ready; the block does not buffer unaccepted commands.
REQ-021 q2_d, q2_c and q2_s SHALL retain their last values in RESP and IDLE.

Reset
REQ-022 On rst assertion, at any state and without waiting for clk, the block SHALL:
- enter IDLE;
- clear rsp_valid, rsp_id, rsp_addr, q2_d, q2_c, q2_s, grant_cnt0 and grant_cnt1 to 0;
- set last_gnt to 1, so req0 wins first.
REQ-023 A command in flight at reset SHALL be discarded with no response.
REQ-024 The first acceptance SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-025 With macro Q2_SCHED_STATS_EN defined, grant_cnt0 and grant_cnt1 SHALL increment on each acceptance for their requester and saturate at 2^CNT_W-1.
REQ-026 Without Q2_SCHED_STATS_EN, grant_cnt0 and grant_cnt1 SHALL remain as ports, tied to 0, with no counter flops.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and the 16-bit width constant.
REQ-028 The two-input round-robin arbiter SHALL be a separate sub-module, rr_arb2 (inputs req[1:0] and last_gnt; outputs gnt[1:0] and gnt_id).
REQ-029 The address unit SHALL stay outside this block.

Verification
REQ-030 The bench SHALL model the address unit as q2_address = q2_d ^ {14'b0, q2_c, q2_s}.
REQ-031 Single requester: req0 d=16'h0002, c=0, s=0, rsp_ready=1 -> req0_ready at N; rsp_valid at N+2 with rsp_id=0 and rsp_addr=16'h0002.
REQ-032 Contention: req0 and req1 valid together with d=16'h00ff (c=0, s=1) and d=16'h0004 (c=1, s=0) -> order req0 then req1, responses 16'h00fe then 16'h0006.
REQ-033 Fairness: both requesters held valid for 6 commands -> grants alternate 0,1,0,1,0,1; with the stats macro, grant_cnt0=3 and grant_cnt1=3.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_addr stable, both readies low; handshake on the cycle rsp_ready rises.
REQ-035 Reset in ISSUE with d=16'hf0a3 -> no response; all outputs 0; next command from req0 is served first.
REQ-036 Saturation: CNT_W=2, 5 req1 commands, stats macro defined -> grant_cnt1=3; without the macro -> grant_cnt1=0.

Source files
------------

// File: rtl/q2_sched_pkg.sv
// Shared definitions for the q2 address-unit scheduler: FSM state encoding and data width.
package q2_sched_pkg;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       gnt_id
);
    always_comb begin
        gnt_id = req[1] & (~req[0] | ~last_gnt);
        gnt    = 2'b00;
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/q2_sched.sv
// Schedules two requesters onto one shared combinational address unit, one command in flight.
// Optional grant statistics counters are built when Q2_SCHED_STATS_EN is defined.
//   state | meaning
//   IDLE  | waiting for a command, readies driven by the arbiter
//   ISSUE | operands held on q2_d/c/s for one cycle, result captured
//   RESP  | rsp_valid held until rsp_ready
module q2_sched
    import q2_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_d,
    input  logic              req0_c,
    input  logic              req0_s,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_d,
    input  logic              req1_c,
    input  logic              req1_s,
    output logic [DATA_W-1:0] q2_d,
    output logic              q2_c,
    output logic              q2_s,
    input  logic [DATA_W-1:0] q2_address,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_addr,
    input  logic              rsp_ready,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);
    state_t     state;
    logic       last_gnt;
    logic [1:0] gnt;
    logic       gnt_id;
    logic       accept;

    rr_arb2 u_arb (
        .req      ({req1_valid, req0_valid}),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    assign accept     = (state == IDLE) && (gnt != 2'b00);
    assign req0_ready = (state == IDLE) && gnt[0];
    assign req1_ready = (state == IDLE) && gnt[1];

    // last_gnt resets to 1 so that req0 wins the first contended arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            q2_d      <= '0;
            q2_c      <= 1'b0;
            q2_s      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q2_d     <= gnt_id ? req1_d : req0_d;
                        q2_c     <= gnt_id ? req1_c : req0_c;
                        q2_s     <= gnt_id ? req1_s : req0_s;
                        rsp_id   <= gnt_id;
                        last_gnt <= gnt_id;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_addr  <= q2_address;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef Q2_SCHED_STATS_EN
    // Saturating acceptance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (req1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif
endmodule
